// File: rtl/mux8_scanner_pkg.sv
// Shared constants and FSM state type for the mux8 channel scanner.
package mux8_scanner_pkg;

    localparam int NCH   = 8;
    localparam int CH_W  = 3;
    localparam int CNT_W = 4;

    localparam logic [CH_W-1:0] CH_LAST = CH_W'(NCH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mux8.sv
// Plain 8:1 multiplexer; channel = {s2,s1,s0}.
module mux8 (
    input  logic d0,
    input  logic d1,
    input  logic d2,
    input  logic d3,
    input  logic d4,
    input  logic d5,
    input  logic d6,
    input  logic d7,
    input  logic s0,
    input  logic s1,
    input  logic s2,
    output logic z0
);

    logic [7:0] d;
    logic [2:0] sel;

    assign d   = {d7, d6, d5, d4, d3, d2, d1, d0};
    assign sel = {s2, s1, s0};
    assign z0  = d[sel];

endmodule

// File: rtl/scan_timer.sv
// Settle down-counter: tick marks the last wait cycle of the current channel.
module scan_timer
    import mux8_scanner_pkg::*;
#(
    parameter int unsigned SETTLE = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic load,
    output logic tick
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // NOTE: the default assignment first keeps every path of always_comb assigned, so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = RELOAD;
        end else if (en) begin
            cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == '0);

endmodule

// File: rtl/mux8_scanner.sv
// Steps mux8 selects through channels 0..7, samples z0 per channel and
// presents the assembled 8-bit word on a valid/ready handshake.
module mux8_scanner
    import mux8_scanner_pkg::*;
#(
    parameter int unsigned SETTLE = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           cont,
    input  logic           z0,
    output logic           s0,
    output logic           s1,
    output logic           s2,
    output logic [NCH-1:0] data,
    output logic           valid,
    input  logic           ready,
    output logic           busy
);

    state_e          state_q;
    logic [CH_W-1:0] ch_q;
    logic [NCH-1:0]  data_q;
    logic            valid_q;
    logic            busy_q;
    logic            tick;

    // Holding the timer in load outside SCAN gives every scan a fresh settle window.
    scan_timer #(
        .SETTLE(SETTLE)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .en  (state_q == SCAN),
        .load(state_q != SCAN),
        .tick(tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ch_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= SCAN;
                        ch_q    <= '0;
                        data_q  <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (tick) begin
                        data_q[ch_q] <= z0;
                        if (ch_q == CH_LAST) begin
                            state_q <= DONE;
                            ch_q    <= '0;
                            busy_q  <= 1'b0;
                            valid_q <= 1'b1;
                        end else begin
                            ch_q <= ch_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (ready) begin
                        valid_q <= 1'b0;
                        if (cont) begin
                            state_q <= SCAN;
                            data_q  <= '0;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ch_q    <= '0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign {s2, s1, s0} = ch_q;
    assign data         = data_q;
    assign valid        = valid_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_mux8_scanner.sv
// Two scanners (SETTLE=0 and SETTLE=2) each driving its own mux8; a monitor
// scoreboards words, latency, select sequencing and handshake behaviour.
`timescale 1ns/1ps
module tb_mux8_scanner;

    logic            clk = 1'b0;
    logic            rst;
    logic            cont;
    logic            ready;
    logic [7:0]      pat;
    logic [1:0]      start_v;
    logic [1:0]      valid_v;
    logic [1:0]      busy_v;
    logic [1:0][7:0] data_v;
    logic [1:0][2:0] sel_v;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic z0, s0, s1, s2;

        mux8 u_mux (
            .d0(pat[0]), .d1(pat[1]), .d2(pat[2]), .d3(pat[3]),
            .d4(pat[4]), .d5(pat[5]), .d6(pat[6]), .d7(pat[7]),
            .s0(s0), .s1(s1), .s2(s2), .z0(z0)
        );

        mux8_scanner #(
            .SETTLE(2 * g)
        ) u_dut (
            .clk  (clk),
            .rst  (rst),
            .start(start_v[g]),
            .cont (cont),
            .z0   (z0),
            .s0   (s0),
            .s1   (s1),
            .s2   (s2),
            .data (data_v[g]),
            .valid(valid_v[g]),
            .ready(ready),
            .busy (busy_v[g])
        );

        assign sel_v[g] = {s2, s1, s0};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic note_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
    endtask

    // Monitor: a word is 'launched' at the edge that registers start (or the
    // accepting edge in continuous mode); channel k is selected during cycles
    // k*(SETTLE+1) .. k*(SETTLE+1)+SETTLE after launch, and valid follows
    // 1 + 8*(SETTLE+1) edges after launch.
    int         launch    [2];
    bit         prev_valid[2];
    bit         acc_prev  [2];
    bit         acc_cont  [2];
    logic [7:0] cur_exp   [2];

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            int per;
            per = 2 * g + 1;
            if (rst) begin
                prev_valid[g] = 1'b0;
                acc_prev[g]   = 1'b0;
                launch[g]     = -1;
            end else begin
                if (acc_prev[g]) begin
                    check("valid_drop", 32'(valid_v[g]), 0);
                    check("busy_after_accept", 32'(busy_v[g]), 32'(acc_cont[g]));
                end
                if (valid_v[g] && !prev_valid[g]) begin
                    if ((g == 0 && exp_q0.size() == 0) || (g == 1 && exp_q1.size() == 0)) begin
                        note_fail("unexpected_word");
                        cur_exp[g] = 'x;
                    end else begin
                        if (g == 0) cur_exp[g] = exp_q0.pop_front();
                        else        cur_exp[g] = exp_q1.pop_front();
                        check("word", 32'(data_v[g]), 32'(cur_exp[g]));
                        check("latency", 32'(cyc + 1 - launch[g]), 32'(1 + 8 * per));
                    end
                end else if (valid_v[g]) begin
                    check("data_hold", 32'(data_v[g]), 32'(cur_exp[g]));
                end
                if (busy_v[g]) begin
                    check("sel_scan", 32'(sel_v[g]), 32'((cyc - launch[g]) / per));
                end else begin
                    check("sel_idle", 32'(sel_v[g]), 0);
                end
                acc_prev[g] = valid_v[g] && ready;
                acc_cont[g] = cont;
                if (!busy_v[g] && !valid_v[g] && start_v[g]) launch[g] = cyc + 1;
                if (valid_v[g] && ready && cont)              launch[g] = cyc + 1;
                prev_valid[g] = valid_v[g];
            end
        end
    end

    task automatic push_exp(input int g, input logic [7:0] w);
        if (g == 0) exp_q0.push_back(w);
        else        exp_q1.push_back(w);
    endtask

    task automatic tick_inputs();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int g);
        start_v[g] = 1'b1;
        tick_inputs();
        start_v[g] = 1'b0;
    endtask

    task automatic wait_valid(input int g, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!valid_v[g] && n < budget);
        if (!valid_v[g]) note_fail("wait_valid_timeout");
        tick_inputs();
    endtask

    // One scan in IDLE with optional random backpressure until the word is taken.
    task automatic run_scan(input int g, input logic [7:0] p, input bit rnd);
        int n    = 0;
        bit done = 1'b0;
        pat = p;
        push_exp(g, p);
        pulse_start(g);
        while (!done && n < 400) begin
            ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            done = valid_v[g] && ready;
            tick_inputs();
            n++;
        end
        ready = 1'b0;
        if (!done) note_fail("scan_timeout");
    endtask

    initial begin
        rst     = 1'b1;
        cont    = 1'b0;
        ready   = 1'b0;
        pat     = 8'h00;
        start_v = 2'b00;
        repeat (3) tick_inputs();
        rst = 1'b0;

        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check("reset_valid", 32'(valid_v[g]), 0);
            check("reset_busy", 32'(busy_v[g]), 0);
            check("reset_data", 32'(data_v[g]), 0);
            check("reset_sel", 32'(sel_v[g]), 0);
        end
        tick_inputs();

        // Single scan, SETTLE=0
        run_scan(0, 8'hA6, 1'b0);

        // Settle window, SETTLE=2
        run_scan(1, 8'h3C, 1'b0);

        // Backpressure: inputs change and start pulses while DONE
        pat = 8'h5A;
        push_exp(0, 8'h5A);
        pulse_start(0);
        wait_valid(0, 40);
        pat = 8'hFF;
        for (int i = 0; i < 20; i++) begin
            start_v[0] = (i % 3 == 0);
            tick_inputs();
        end
        start_v[0] = 1'b0;
        @(negedge clk);
        check("bp_valid", 32'(valid_v[0]), 1);
        check("bp_data", 32'(data_v[0]), 32'h5A);
        tick_inputs();
        ready = 1'b1;
        tick_inputs();
        ready = 1'b0;

        // Continuous mode: F0 then 0F, cont dropped during the second scan
        pat  = 8'hF0;
        cont = 1'b1;
        push_exp(0, 8'hF0);
        push_exp(0, 8'h0F);
        pulse_start(0);
        wait_valid(0, 40);
        pat   = 8'h0F;
        ready = 1'b1;
        tick_inputs();
        cont = 1'b0;
        wait_valid(0, 40);
        ready = 1'b0;
        repeat (2) tick_inputs();
        @(negedge clk);
        check("cont_end_idle", 32'(busy_v[0]), 0);
        tick_inputs();

        // Reset mid-scan at channel 4
        pat = 8'hC3;
        push_exp(0, 8'hC3);
        pulse_start(0);
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (sel_v[0] != 3'd4 && n < 20);
            if (sel_v[0] != 3'd4) note_fail("reach_ch4_timeout");
        end
        tick_inputs();
        rst = 1'b1;
        exp_q0.delete();
        repeat (2) tick_inputs();
        rst = 1'b0;
        @(negedge clk);
        check("rst_sel", 32'(sel_v[0]), 0);
        check("rst_data", 32'(data_v[0]), 0);
        check("rst_valid", 32'(valid_v[0]), 0);
        check("rst_busy", 32'(busy_v[0]), 0);
        repeat (4) @(negedge clk);
        check("rst_stays_idle", 32'(busy_v[0]), 0);
        tick_inputs();

        // start and rst together: reset wins
        rst        = 1'b1;
        start_v[0] = 1'b1;
        tick_inputs();
        rst        = 1'b0;
        start_v[0] = 1'b0;
        @(negedge clk);
        check("start_rst_busy", 32'(busy_v[0]), 0);
        repeat (3) @(negedge clk);
        check("start_rst_idle", 32'({busy_v[0], valid_v[0]}), 0);
        tick_inputs();

        // Randomized patterns with random backpressure on both scanners
        for (int i = 0; i < 6; i++) run_scan(0, 8'($urandom), 1'b1);
        for (int i = 0; i < 3; i++) run_scan(1, 8'($urandom), 1'b1);

        repeat (3) tick_inputs();
        check("q0_drained", 32'(exp_q0.size()), 0);
        check("q1_drained", 32'(exp_q1.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
